dram_access_seq: RTL
====================

# dram_access_seq

Memory-stage access sequencer for the pipelined CPU. It sits between the MEM stage and a word-wide, single-port synchronous data RAM. It turns a decoded load/store request into the RAM cycle sequence: read, read-modify-write for byte/half stores, or direct write for word stores. It also sign/zero-extends load data, flags misaligned accesses, and stalls the pipeline until each access completes.

## Interface
- `ADDR_W`, default 16: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `cpu_clk` in 1: clock; all state changes on the rising edge.
- `cpu_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM stage holds a load/store; held stable until the cycle `resp_valid`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: load zero-extend (LD.BU/LD.HU); ignored for word and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `stall` out 1: freeze the pipeline this cycle.
- `resp_valid` out 1: one-cycle pulse; access finished.
- `resp_err` out 1: with `resp_valid`, the access was misaligned/reserved and was not performed.
- `resp_rdata` out 32: extended load result; meaningful only when `resp_valid`=1 on a successful load.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_we` out 1: RAM full-word write enable.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_addr` is presented with `ram_we`=0.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP. State and request latches are flops with asynchronous clear.
- **IDLE, `req_valid`=1:**
  - Latch addr, size, we, unsigned and wdata.
  - Evaluate alignment. Misaligned means: half with addr[0]=1; word with addr[1:0]≠00; size=11.
  - Misaligned → RESP with err=1. No RAM cycle.
  - Load or sub-word store → RD_ISSUE.
  - Word store → WR, with `ram_wdata`=wdata.
- **RD_ISSUE:** `ram_addr` = latched addr[ADDR_W+1:2], `ram_we`=0. Next state is RD_WAIT.
- **RD_WAIT:** capture `ram_rdata`.
  - Load: form result → RESP.
  - Store: form merged word → WR.
- **WR:** `ram_we`=1 with the merged or word data. Next state is RESP.
- **RESP:** `resp_valid`=1 and `stall`=0, so the pipeline advances at this edge. Next state is IDLE unconditionally. Request inputs seen during RESP are never re-accepted.
- **Load extension:**
  - Byte lane is selected by addr[1:0]; half lane is selected by addr[1].
  - Sign-extend from bit 7 or 15, unless `req_unsigned`=1, in which case zero-extend.
  - Word is passed through unchanged.
- **Store merge:**
  - Byte: replace bits [8·addr[1:0]+7 : 8·addr[1:0]] with wdata[7:0].
  - Half: replace the 16-bit lane at addr[1] with wdata[15:0].
  - All other bits keep their RAM value.
- Address bits above ADDR_W+1 are ignored; there is no bounds error.
- `stall` = (IDLE ∧ `req_valid`) ∨ RD_ISSUE ∨ RD_WAIT ∨ WR. This is a combinational function of state and `req_valid`.

## Timing
- Request seen at IDLE in cycle 0. Cycle counts to the `resp_valid` cycle:
  - Load: cycle 3.
  - Byte/half store: cycle 4.
  - Word store: cycle 2.
  - Misaligned: cycle 1.
- `stall` is high from cycle 0 through the cycle before RESP. It is low in RESP.
- Back-to-back requests: the next request is first considered in the IDLE cycle after RESP.
- **Reset values:**
  - state=IDLE, `stall`=0 (with `req_valid`=0), `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
- Reset asserted mid-access drops `ram_we` immediately, asynchronously. No partial write completes after the reset edge, and no response is produced.
- `ram_we` is high for exactly one cycle per successful store, and never high for loads or errors.
- `resp_rdata` holds its last value outside RESP. For stores and errors it is 0 in RESP.

## Test plan
- **Word store then load:**
  - Store addr 0x10, data 0xDEADBEEF → `ram_we` for one cycle at word 4; `resp_valid` at cycle 2.
  - Load word 0x10 → `resp_rdata`=0xDEADBEEF at cycle 3; `stall` high in cycles 0–2.
- **Byte loads from word 4 = 0x80FF7F01:**
  - LD.B 0x13 → 0xFFFFFF80.
  - LD.BU 0x13 → 0x00000080.
  - LD.B 0x10 → 0x00000001.
- **Sub-word stores into word 4 = 0x11223344:**
  - ST.B 0x11, data 0xAB → RAM word becomes 0x1122AB44.
  - ST.H 0x12, data 0xBEEF → RAM word becomes 0xBEEFAB44.
  - `resp_valid` for each at cycle 4.
- **Misalignment:**
  - Half at 0x11, word at 0x12, and size=11 each give `resp_valid`=`resp_err`=1 at cycle 1.
  - `ram_we` is never asserted and RAM is unchanged.
- **Back-to-back:** a load immediately followed by a store, with `req_valid` held continuously → exactly one `resp_valid` per request; the second request is accepted only in the IDLE cycle after the first RESP.
- **Reset mid-RMW:** assert `cpu_rst_n`=0 during RD_WAIT of ST.B → all outputs 0 at once, RAM word unmodified, state IDLE after release.

Source files
------------

// File: rtl/dram_access_seq_if.sv
// Bus bundle between the MEM stage, the access sequencer and the data RAM.
//   req_*      : decoded load/store request, held by the MEM stage until resp_valid
//   stall      : pipeline freeze for the current cycle
//   resp_*     : one-cycle completion pulse, error flag and extended load data
//   ram_*      : word-wide single-port synchronous RAM port
// slave  = sequencer view, master = environment (MEM stage + RAM) view.
interface dram_access_seq_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  ram_rdata,
    output stall, resp_valid, resp_err, resp_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output ram_rdata,
    input  stall, resp_valid, resp_err, resp_rdata,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/dram_access_seq.sv
// Memory-stage access sequencer: turns a load/store request into RAM cycles
// (read, read-modify-write for byte/half stores, direct write for word stores),
// extends load data, rejects misaligned/reserved accesses and stalls the
// pipeline until the access completes.
// Ports:
//   cpu_clk    : clock, rising edge
//   cpu_rst_n  : asynchronous active-low reset
//   bus        : dram_access_seq_if.slave (request, response, stall, RAM port)
// stall is the only combinational output; everything else is registered.
module dram_access_seq #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  dram_access_seq_if.slave bus
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Latched request; only the RAM-visible address bits are kept.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] waddr;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              stall_c;
  logic              misaligned_c;
  logic [DATA_W-1:0] load_val_c;
  logic [DATA_W-1:0] merge_val_c;

  // Address bits above the RAM range are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  // Select the addressed lane and sign/zero-extend it.
  function automatic logic [DATA_W-1:0] load_ext(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay the store data onto the word read back from RAM.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        off,
    input logic [1:0]        size,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    r = w;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Alignment check on the live request (evaluated only in IDLE).
  always_comb begin
    misaligned_c = 1'b0;
    case (bus.req_size)
      SZ_BYTE: misaligned_c = 1'b0;
      SZ_HALF: misaligned_c = bus.req_addr[0];
      SZ_WORD: misaligned_c = (bus.req_addr[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
  end

  assign load_val_c  = load_ext(bus.ram_rdata, req_q.off, req_q.size, req_q.uns);
  assign merge_val_c = store_merge(bus.ram_rdata, req_q.off, req_q.size, req_q.wdata);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          stall_c     = 1'b1;
          req_d.we    = bus.req_we;
          req_d.size  = bus.req_size;
          req_d.uns   = bus.req_unsigned;
          req_d.waddr = bus.req_addr[ADDR_W+1:2];
          req_d.off   = bus.req_addr[1:0];
          req_d.wdata = bus.req_wdata;
          if (misaligned_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
            state_d     = WR;
            ram_we_d    = 1'b1;
            ram_addr_d  = bus.req_addr[ADDR_W+1:2];
            ram_wdata_d = bus.req_wdata;
          end else begin
            state_d    = RD_ISSUE;
            ram_addr_d = bus.req_addr[ADDR_W+1:2];
          end
        end
      end

      RD_ISSUE: begin
        stall_c = 1'b1;
        state_d = RD_WAIT;
      end

      // RAM data for the address presented in RD_ISSUE is valid here.
      RD_WAIT: begin
        stall_c = 1'b1;
        if (req_q.we) begin
          state_d     = WR;
          ram_we_d    = 1'b1;
          ram_wdata_d = merge_val_c;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_val_c;
        end
      end

      WR: begin
        stall_c      = 1'b1;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end

      // Always return to IDLE so a held request is not re-accepted.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and output registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule
